sram_array_ctrl: RTL and testbench

//  Access sequencer that sits directly upstream of a DEPTH x WIDTH array of 6T SRAMcell instances.

---
 rtl/sram_array_ctrl.sv | 142 ++++++++++++++
 tb/tb_sram_array_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/sram_array_ctrl.sv
// sram_array_ctrl: single-outstanding access sequencer for a DEPTH x WIDTH
// 6T SRAM array. Sequence per op: SETUP -> PULSE x PULSE_CYCLES -> HOLD -> RESP.
// Optional build macro: SRAM_CTRL_DIFF_CHECK_EN (flag non-complementary
// sense bitlines as a read error).
module sram_array_ctrl #(
  parameter int DEPTH        = 16,
  parameter int WIDTH        = 8,
  parameter int ADDR_W       = 4,
  parameter int PULSE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WIDTH-1:0]  req_wdata,
  output logic              rsp_valid,
  output logic [WIDTH-1:0]  rsp_rdata,
  output logic              rsp_err,
  output logic [DEPTH-1:0]  wl,
  output logic [WIDTH-1:0]  bl1_drv,
  output logic [WIDTH-1:0]  bl2_drv,
  output logic              read_pulse,
  output logic              write_pulse,
  input  logic [WIDTH-1:0]  bl1_sense,
  input  logic [WIDTH-1:0]  bl2_sense
);

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, RESP} state_t;

  state_t             state, state_nxt;
  logic [3:0]         cnt, cnt_nxt;
  logic               we_q, oor_q, diff_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [WIDTH-1:0]   wdata_q;

  // view of the op as it will be after this edge (fields captured on accept)
  logic               accept, last_pulse, capture, diff_fail;
  logic               we_n, oor_n, act_n;
  logic [ADDR_W-1:0]  addr_n;
  logic [WIDTH-1:0]   wdata_n;

  // registered-output next values, so strobes to the array are glitch-free
  logic [DEPTH-1:0]   wl_nxt;
  logic [WIDTH-1:0]   bl1_nxt, bl2_nxt;
  logic               rp_nxt, wp_nxt, rv_nxt, err_nxt;

  assign req_ready  = (state == IDLE);
  assign accept     = req_valid && req_ready;
  assign last_pulse = (state == PULSE) && (cnt == 4'(PULSE_CYCLES - 1));
  assign capture    = last_pulse && !we_q && !oor_q;

  assign we_n    = accept ? req_we    : we_q;
  assign addr_n  = accept ? req_addr  : addr_q;
  assign wdata_n = accept ? req_wdata : wdata_q;
  assign oor_n   = accept ? ({1'b0, req_addr} >= (ADDR_W+1)'(DEPTH)) : oor_q;

`ifdef SRAM_CTRL_DIFF_CHECK_EN
  // x/z on either sense line also counts as a failed differential pair
  assign diff_fail = (bl1_sense !== ~bl2_sense);
`else
  logic unused_bl2;
  assign unused_bl2 = ^bl2_sense;
  assign diff_fail  = 1'b0;
`endif

  // next state and pulse counter
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE:  if (accept) state_nxt = SETUP;
      SETUP: begin state_nxt = PULSE; cnt_nxt = '0; end
      PULSE: begin
        if (last_pulse) begin state_nxt = HOLD; cnt_nxt = '0; end
        else            cnt_nxt = cnt + 4'd1;
      end
      HOLD:  state_nxt = RESP;
      RESP:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // next array-facing outputs, decoded from the next state
  always_comb begin
    act_n   = (state_nxt == SETUP) || (state_nxt == PULSE) || (state_nxt == HOLD);
    wl_nxt  = '0;
    for (int i = 0; i < DEPTH; i++)
      wl_nxt[i] = act_n && !oor_n && (addr_n == ADDR_W'(i));
    bl1_nxt = (act_n && we_n) ?  wdata_n : '0;
    bl2_nxt = (act_n && we_n) ? ~wdata_n : '0;
    rp_nxt  = (state_nxt == PULSE) && !we_n && !oor_n;
    wp_nxt  = (state_nxt == PULSE) &&  we_n && !oor_n;
    rv_nxt  = (state_nxt == RESP);
    // entering RESP only happens from HOLD, so oor_q/diff_q are settled
    err_nxt = rv_nxt && (oor_q || diff_q);
  end

  // state, request capture, read capture and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      we_q        <= 1'b0;
      oor_q       <= 1'b0;
      diff_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_rdata   <= '0;
      wl          <= '0;
      bl1_drv     <= '0;
      bl2_drv     <= '0;
      read_pulse  <= 1'b0;
      write_pulse <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        oor_q   <= oor_n;
        diff_q  <= 1'b0;
      end
      if (capture) begin
        rsp_rdata <= bl1_sense;
        diff_q    <= diff_fail;
      end
      wl          <= wl_nxt;
      bl1_drv     <= bl1_nxt;
      bl2_drv     <= bl2_nxt;
      read_pulse  <= rp_nxt;
      write_pulse <= wp_nxt;
      rsp_valid   <= rv_nxt;
      rsp_err     <= err_nxt;
    end
  end

endmodule

// File: tb/tb_sram_array_ctrl.sv
// Bench for sram_array_ctrl: behavioural cell array on the bitlines, a
// scoreboard of expected responses, and per-op word-line / strobe checks.
module tb_sram_array_ctrl;
  localparam int DEPTH = 16, WIDTH = 8, ADDR_W = 5, PC = 2;
  localparam int LAT = PC + 3;
`ifdef SRAM_CTRL_DIFF_CHECK_EN
  localparam bit DIFF_ON = 1'b1;
`else
  localparam bit DIFF_ON = 1'b0;
`endif

  logic              clk, rst_n;
  logic              req_valid, req_ready, req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [WIDTH-1:0]  req_wdata;
  logic              rsp_valid, rsp_err;
  logic [WIDTH-1:0]  rsp_rdata;
  logic [DEPTH-1:0]  wl;
  logic [WIDTH-1:0]  bl1_drv, bl2_drv;
  logic              read_pulse, write_pulse;
  wire  [WIDTH-1:0]  bl1_sense, bl2_sense;

  sram_array_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_W(ADDR_W), .PULSE_CYCLES(PC)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .wl(wl), .bl1_drv(bl1_drv), .bl2_drv(bl2_drv),
    .read_pulse(read_pulse), .write_pulse(write_pulse),
    .bl1_sense(bl1_sense), .bl2_sense(bl2_sense));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cell array stand-in: latch on write_pulse fall, drive sense during read_pulse
  logic [WIDTH-1:0] cells [DEPTH];
  logic [WIDTH-1:0] row_data;
  logic             corrupt;
  always @(negedge write_pulse)
    for (int i = 0; i < DEPTH; i++) if (wl[i]) cells[i] <= bl1_drv;
  always_comb begin
    row_data = '0;
    for (int i = 0; i < DEPTH; i++) if (wl[i]) row_data = cells[i];
  end
  assign bl1_sense = (read_pulse && |wl) ? row_data : 'z;
  assign bl2_sense = (read_pulse && |wl) ? (corrupt ? row_data : ~row_data) : 'z;

  int n_tests = 0, n_fail = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct { logic [WIDTH-1:0] rd; logic err; int acc; } exp_t;
  exp_t exp_q [$];
  logic [WIDTH-1:0] last_rd;

  // response monitor: every rsp_valid must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (exp_q.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rd));
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
        chk("rsp_latency", 32'(cyc - e.acc), 32'(LAT));
      end
    end
  end

  task automatic wait_ready(output bit ok);
    int t = 0;
    @(negedge clk);
    while (!req_ready && t < 50) begin @(negedge clk); t++; end
    ok = req_ready;
    if (!ok) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  // issue one op, then watch it to completion
  task automatic do_op(input logic we, input logic [ADDR_W-1:0] addr,
                       input logic [WIDTH-1:0] wd, input logic [WIDTH-1:0] rd_exp);
    bit ok, seen, rp_seen, wp_seen, bl_bad, oor;
    logic [DEPTH-1:0] wl_or, exp_wl, one;
    exp_t e;
    int t;
    one = DEPTH'(1);
    oor = (int'(addr) >= DEPTH);
    exp_wl = oor ? '0 : (one << addr);
    e.rd  = (we || oor) ? last_rd : rd_exp;
    e.err = oor || (DIFF_ON && !we && corrupt);
    wait_ready(ok);
    if (!ok) return;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
    e.acc = cyc;
    exp_q.push_back(e);
    last_rd = e.rd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = ~addr; req_wdata = ~wd; req_we = ~we;
    wl_or = '0; seen = 0; rp_seen = 0; wp_seen = 0; bl_bad = 0; t = 0;
    while (!seen && t < 20) begin
      @(negedge clk);
      wl_or |= wl;
      if (read_pulse) begin rp_seen = 1; if (bl1_drv != 0 || bl2_drv != 0) bl_bad = 1; end
      if (write_pulse) begin wp_seen = 1; if (bl1_drv != wd || bl2_drv != ~wd) bl_bad = 1; end
      seen = rsp_valid;
      t++;
    end
    if (!seen) chk("rsp_timeout", 32'd0, 32'd1);
    chk("wl_onehot", 32'(wl_or), 32'(exp_wl));
    chk("write_pulse_seen", 32'(wp_seen), 32'(we && !oor));
    chk("read_pulse_seen", 32'(rp_seen), 32'(!we && !oor));
    chk("bitline_drive", 32'(bl_bad), 32'd0);
  endtask

  logic [WIDTH-1:0] mem_exp [DEPTH];

  initial begin
    bit ok;
    int t;
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int t;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    corrupt = 1'b0; last_rd = '0;
    repeat (3) @(negedge clk);
    chk("rst_wl", 32'(wl), 32'd0);
    chk("rst_bl", 32'({bl1_drv, bl2_drv}), 32'd0);
    chk("rst_pulses", 32'({read_pulse, write_pulse}), 32'd0);
    chk("rst_rsp", 32'({rsp_valid, rsp_err, rsp_rdata}), 32'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);

    do_op(1'b1, 5'd3, 8'hA5, 8'h00);
    do_op(1'b0, 5'd3, 8'h00, 8'hA5);
    do_op(1'b1, 5'd3, 8'h5A, 8'h00);
    do_op(1'b1, 5'd7, 8'hFF, 8'h00);
    do_op(1'b0, 5'd3, 8'h00, 8'h5A);
    do_op(1'b0, 5'd7, 8'h00, 8'hFF);
    do_op(1'b0, 5'd20, 8'h00, 8'h00);   // out of range: err, rdata held at 0xFF
    do_op(1'b1, 5'd16, 8'h11, 8'h00);   // first out-of-range address

    // abort a write mid-pulse with reset
    wait_ready(ok);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 5'd9; req_wdata = 8'h3C;
    @(posedge clk); #1 req_valid = 1'b0;
    t = 0;
    while (!write_pulse && t < 10) begin @(negedge clk); t++; end
    chk("abort_pulse_up", 32'({write_pulse, wl[9]}), 32'b11);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_pulse_wl_fall", 32'({write_pulse, |wl}), 32'd0);
    exp_q.delete();
    last_rd = '0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (8) @(negedge clk);           // monitor flags any stray rsp_valid
    do_op(1'b0, 5'd7, 8'h00, 8'hFF);

    // complementary-sense check
    corrupt = 1'b1;
    do_op(1'b0, 5'd3, 8'h00, 8'h5A);
    corrupt = 1'b0;
    do_op(1'b0, 5'd3, 8'h00, 8'h5A);

    // random write/read-back across rows 0..15
    for (int r = 0; r < DEPTH; r++) mem_exp[r] = 8'h00;
    for (int k = 0; k < 6; k++) begin
      int row;
      logic [WIDTH-1:0] d;
      row = $urandom_range(0, DEPTH - 1);
      d = WIDTH'($urandom);
      if (row == 9) row = 10;            // row 9 undefined after abort
      do_op(1'b1, ADDR_W'(row), d, 8'h00);
      mem_exp[row] = d;
      do_op(1'b0, ADDR_W'(row), 8'h00, mem_exp[row]);
    end
    do_op(1'b0, 5'd7, 8'h00, (mem_exp[7] != 8'h00) ? mem_exp[7] : 8'hFF);

    repeat (4) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
